// File: rtl/sw_input_ctrl_if.sv
// rtl/sw_input_ctrl_if.sv - switch input/debounced output bundle for sw_input_ctrl
interface sw_input_ctrl_if #(
    parameter int N_SW = 4
);
    logic [N_SW-1:0] i_sw;
    logic [N_SW-1:0] o_sw;
    logic [N_SW-1:0] o_rise;
    logic [N_SW-1:0] o_fall;
    logic            o_change;
    logic            o_enable;
    logic [1:0]      o_sel;
    logic            o_dir;

    modport slave (
        input  i_sw,
        output o_sw, o_rise, o_fall, o_change, o_enable, o_sel, o_dir
    );

    modport master (
        output i_sw,
        input  o_sw, o_rise, o_fall, o_change, o_enable, o_sel, o_dir
    );
endinterface

// File: rtl/sw_input_ctrl.sv
// rtl/sw_input_ctrl.sv - switch synchronizer/debouncer with edge strobes (debounce FSMs under SW_DEBOUNCE_EN)
module sw_input_ctrl #(
    parameter int N_SW      = 4,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           i_rst,
    sw_input_ctrl_if.slave sw_if
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [N_SW-1:0] sync1_q, sync1_d;
    logic [N_SW-1:0] sync2_q, sync2_d;
    logic [N_SW-1:0] o_sw_q, o_sw_d;
    logic [N_SW-1:0] rise_q, rise_d;
    logic [N_SW-1:0] fall_q, fall_d;
    logic            change_q, change_d;
    logic [3:0]      sw4;

    always_comb begin
        sync1_d = sw_if.i_sw;
        sync2_d = sync1_q;
    end

`ifdef SW_DEBOUNCE_EN
    typedef enum logic {ST_STABLE, ST_COUNT} state_t;

    state_t          state_q [N_SW];
    state_t          state_d [N_SW];
    logic [CW-1:0]   cnt_q   [N_SW];
    logic [CW-1:0]   cnt_d   [N_SW];

    // Any sample matching o_sw during COUNT aborts the window, so bounces restart it.
    always_comb begin
        o_sw_d = o_sw_q;
        for (int i = 0; i < N_SW; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync2_q[i] != o_sw_q[i]) begin
                        state_d[i] = ST_COUNT;
                        cnt_d[i]   = CW'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                ST_COUNT: begin
                    if (sync2_q[i] == o_sw_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CW'(DB_CYCLES)) begin
                        o_sw_d[i]  = ~o_sw_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SW; i++) begin
            if (i_rst) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        o_sw_d = sync2_q;
    end
`endif

    // Strobes are computed from the next/current o_sw pair so they line up with the new level.
    always_comb begin
        rise_d   = o_sw_d & ~o_sw_q;
        fall_d   = ~o_sw_d & o_sw_q;
        change_d = |(o_sw_d ^ o_sw_q);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            o_sw_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            o_sw_q   <= o_sw_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sw4
        if (g < N_SW) begin : g_bit
            assign sw4[g] = o_sw_q[g];
        end else begin : g_zero
            assign sw4[g] = 1'b0;
        end
    end

    assign sw_if.o_sw     = o_sw_q;
    assign sw_if.o_rise   = rise_q;
    assign sw_if.o_fall   = fall_q;
    assign sw_if.o_change = change_q;
    assign sw_if.o_enable = sw4[0];
    assign sw_if.o_sel    = sw4[2:1];
    assign sw_if.o_dir    = sw4[3];
endmodule

// File: tb/tb_sw_input_ctrl.sv
// tb/tb_sw_input_ctrl.sv - randomized self-checking bench for sw_input_ctrl against a sample-history model
module tb_sw_input_ctrl;
    localparam int DB = 8;
`ifdef SW_DEBOUNCE_EN
    localparam int LAT        = DB + 2;
    localparam int GLITCH_CHG = 0;
`else
    localparam int LAT        = 2;
    localparam int GLITCH_CHG = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sw_input_ctrl_if #(.N_SW(4)) sw_if ();

    sw_input_ctrl #(.N_SW(4), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .i_rst (rst),
        .sw_if (sw_if)
    );

    // Reference: o_sw bit flips once DB+1 consecutive synchronized samples disagree with it.
    logic [3:0] hist [$];
    logic [3:0] m_sw = '0, m_rise = '0, m_fall = '0;
    logic       m_chg = 1'b0;
    int         run [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        logic [3:0] sv, nxt;
        if (rst) begin
            hist.delete();
            m_sw = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
            for (int b = 0; b < 4; b++) run[b] = 0;
        end else begin
            hist.push_back(sw_if.i_sw);
            sv  = (hist.size() >= 3) ? hist[hist.size() - 3] : 4'b0000;
            nxt = m_sw;
`ifdef SW_DEBOUNCE_EN
            for (int b = 0; b < 4; b++) begin
                if (sv[b] != m_sw[b]) begin
                    run[b] = run[b] + 1;
                    if (run[b] == DB + 1) begin
                        nxt[b] = ~m_sw[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
`else
            nxt = sv;
`endif
            m_rise = nxt & ~m_sw;
            m_fall = ~nxt & m_sw;
            m_chg  = (nxt != m_sw);
            m_sw   = nxt;
        end
    end

    function automatic logic [16:0] obs_vec();
        return {sw_if.o_sw, sw_if.o_rise, sw_if.o_fall, sw_if.o_change,
                sw_if.o_enable, sw_if.o_sel, sw_if.o_dir};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_sw, m_rise, m_fall, m_chg, m_sw[0], m_sw[2:1], m_sw[3]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sw_if.i_sw = 4'($urandom);
            @(negedge clk);
            checks++;
            if (obs_vec() !== 17'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", c, obs_vec(), 17'h0);
            end
        end
    endtask

    task automatic test_single_rise();
        int found = -1, rises = 0, chgs = 0;
        rst = 1'b1; sw_if.i_sw = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        sw_if.i_sw = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_rise_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (sw_if.o_sw == 4'b0001 && found < 0) found = k;
            if (sw_if.o_rise == 4'b0001) rises++;
            if (sw_if.o_change) chgs++;
        end
        checks++;
        if (found - 1 !== LAT) begin
            errors++;
            $display("FAIL single_rise_latency got=%0d exp=%0d", found - 1, LAT);
        end
        checks++;
        if (rises !== 1 || chgs !== 1) begin
            errors++;
            $display("FAIL single_rise_pulses rises=%0d chgs=%0d exp=1/1", rises, chgs);
        end
    endtask

    task automatic test_glitch();
        int chgs = 0;
        sw_if.i_sw = 4'b0011;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 4) sw_if.i_sw = 4'b0001;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL glitch_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (sw_if.o_change) chgs++;
        end
        checks++;
        if (chgs !== GLITCH_CHG || sw_if.o_sw !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_changes chgs=%0d sw=%b exp=%0d/0001", chgs, sw_if.o_sw, GLITCH_CHG);
        end
    endtask

    task automatic test_bounce();
        int found = -1, rises = 0;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) sw_if.i_sw[2] = ~sw_if.i_sw[2];
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        sw_if.i_sw[2] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_hold_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (sw_if.o_rise[2]) begin
                rises++;
                if (found < 0) found = k;
            end
        end
        checks++;
        if (rises !== 1 || found - 1 !== LAT) begin
            errors++;
            $display("FAIL bounce_single_rise rises=%0d lat=%0d exp=1/%0d", rises, found - 1, LAT);
        end
        checks++;
        if (sw_if.o_sel !== 2'b10) begin
            errors++;
            $display("FAIL bounce_sel got=%b exp=10", sw_if.o_sel);
        end
    endtask

    task automatic test_back_to_back();
        int chgs = 0;
        logic [3:0] rise_seen = '0;
        rst = 1'b1; sw_if.i_sw = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        sw_if.i_sw = 4'b1010;
        for (int k = 1; k <= LAT + 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL simul_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (sw_if.o_change) begin
                chgs++;
                rise_seen = sw_if.o_rise;
            end
        end
        checks++;
        if (chgs !== 1 || rise_seen !== 4'b1010) begin
            errors++;
            $display("FAIL simul_strobe chgs=%0d rise=%b exp=1/1010", chgs, rise_seen);
        end
        checks++;
        if ({sw_if.o_sel, sw_if.o_dir, sw_if.o_enable} !== 4'b0110) begin
            errors++;
            $display("FAIL simul_fields got=%b exp=0110", {sw_if.o_sel, sw_if.o_dir, sw_if.o_enable});
        end
    endtask

    task automatic test_reset_midcount();
        int found = -1;
        rst = 1'b1; sw_if.i_sw = 4'b0000;
        @(negedge clk);
        rst = 1'b0; sw_if.i_sw = 4'b1111;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_vec() !== 17'h0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h exp=%h", obs_vec(), 17'h0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (sw_if.o_sw == 4'b1111 && found < 0) begin
                found = k;
                checks++;
                if (sw_if.o_rise !== 4'b1111 || sw_if.o_change !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_rise rise=%b chg=%b exp=1111/1", sw_if.o_rise, sw_if.o_change);
                end
            end
        end
        checks++;
        if (found - 1 !== LAT) begin
            errors++;
            $display("FAIL midreset_latency got=%0d exp=%0d", found - 1, LAT);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 5) == 0)
                sw_if.i_sw[$urandom_range(0, 3)] = ~sw_if.i_sw[$urandom_range(0, 3)];
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        sw_if.i_sw = 4'b0000;
        test_reset();
        test_single_rise();
        test_glitch();
        test_bounce();
        test_back_to_back();
        test_reset_midcount();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sw_input_ctrl.md
SW_INPUT_CTRL -- requirements
Module: sw_input_ctrl

Interface
REQ-001 SHALL provide parameter N_SW, default 4: number of switch inputs.
REQ-002 SHALL provide parameter DB_CYCLES, default 1_000_000: debounce window in clocks (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 SHALL provide port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL provide port i_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL provide port i_sw, input, N_SW: raw, asynchronous, bouncing switch levels.
REQ-006 SHALL provide port o_sw, output, N_SW: debounced switch levels.
REQ-007 SHALL provide port o_rise, output, N_SW: one-cycle pulse per bit on a debounced 0->1 transition.
REQ-008 SHALL provide port o_fall, output, N_SW: one-cycle pulse per bit on a debounced 1->0 transition.
REQ-009 SHALL provide port o_change, output, 1: one-cycle strobe when any o_sw bit changes.
REQ-010 SHALL provide port o_enable, output, 1: equal to o_sw[0].
REQ-011 SHALL provide port o_sel, output, 2: equal to o_sw[2:1].
REQ-012 SHALL provide port o_dir, output, 1: equal to o_sw[3].

Function
REQ-013 SHALL pass each i_sw bit through a two-flop synchronizer before any other use.
REQ-014 SHALL give each bit an independent FSM with states STABLE and COUNT, plus a counter sized ceil(log2(DB_CYCLES+1)) bits.
REQ-015 In STABLE, SHALL enter COUNT with the counter at 1 when the synchronized bit differs from o_sw; otherwise SHALL remain in STABLE with the counter at 0.
REQ-016 In COUNT, SHALL return to STABLE and clear the counter if the synchronized bit equals o_sw again (glitch rejected, no output change).
REQ-017 In COUNT, SHALL increment the counter while the bit still differs; on the edge where the counter equals DB_CYCLES, SHALL toggle o_sw, clear the counter and return to STABLE.
REQ-018 Latency: a steady raw change SHALL appear on o_sw exactly DB_CYCLES+2 clocks after the first edge that samples it.
REQ-019 o_rise, o_fall and o_change SHALL be registered and asserted only in the single cycle in which o_sw holds the new value.
REQ-020 Bits settling on the same edge SHALL produce one o_change strobe, with every affected bit set in o_rise/o_fall.
REQ-021 Any bounce within the window SHALL restart the count, so a bouncing input yields exactly one transition once stable.
REQ-022 The counter SHALL never wrap; it saturates by construction at DB_CYCLES.
REQ-023 o_enable, o_sel and o_dir SHALL be pure wiring from o_sw with no added latency; if N_SW<4, missing bits SHALL read 0.

Reset
REQ-024 While i_rst=1 at a clock edge, SHALL clear synchronizers, counters, o_sw, o_rise, o_fall and o_change to 0, and set all FSMs to STABLE.
REQ-025 Reset mid-count SHALL discard the pending transition; counting SHALL restart from the first edge after release.
REQ-026 A switch held at 1 through reset SHALL generate o_rise and o_change DB_CYCLES+2 clocks after release.

Configuration
REQ-027 With macro SW_DEBOUNCE_EN defined, SHALL implement REQ-014..REQ-022.
REQ-028 Without SW_DEBOUNCE_EN, SHALL omit the FSMs and counters and drive o_sw directly from the synchronizer output (latency 2 clocks); edge pulses and o_change still apply; DB_CYCLES is ignored.

Verification (DB_CYCLES=8, SW_DEBOUNCE_EN defined unless stated)
REQ-029 i_sw 0000->0001 held -> o_sw=0001 10 clocks after first sampling edge; o_rise=0001 and o_change=1 for exactly that one cycle.
REQ-030 i_sw[1] high 5 clocks then low -> o_sw stays 0000; no o_rise, o_fall or o_change pulses.
REQ-031 i_sw[2] toggling every 3 clocks for 30 clocks, then held high -> single o_rise=0100, 10 clocks after the last toggle; o_sel=10.
REQ-032 i_sw 0000->1010 on one edge -> one o_change, o_rise=1010 for one cycle; o_sel=01, o_dir=1, o_enable=0.
REQ-033 i_sw=1111, i_rst pulsed at count 5 -> all outputs 0 during reset; o_sw=1111 exactly 10 clocks after release.
REQ-034 Macro undefined, i_sw 0000->0001 -> o_sw=0001 2 clocks later with a one-cycle o_rise[0].
